load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the stage-2 pipeline register. It consumes the effective address, store data, load size/sign and destination register from that register. It runs a request/grant/response handshake on the data-memory bus and stalls upstream while an access is outstanding. It returns aligned, sign- or zero-extended load data plus a register-file write strobe to write-back.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles allowed in REQ+WAIT before abort (used only when LSU_TIMEOUT_EN is defined)

Ports:
clk_in  input  1  clock; all state on rising edge
rst_in  input  1  synchronous, active-low reset
valid_in  input  1  stage-2 register holds a valid instruction
mem_rd_req_in  input  1  instruction is a load
mem_wr_req_in  input  1  instruction is a store (rd and wr never both set)
iadder_in  input  32  effective byte address
rs2_in  input  32  store data
load_size_in  input  2  00 byte, 01 half, 10/11 word (applies to stores too)
load_unsigned_in  input  1  1 = zero-extend load, 0 = sign-extend
rd_addr_in  input  5  destination register
rf_wr_en_in  input  1  instruction writes rd
dmem_req_out  output  1  bus request, held until granted
dmem_we_out  output  1  1 = write
dmem_addr_out  output  32  word-aligned address {addr[31:2],2'b00}
dmem_wdata_out  output  32  lane-replicated store data
dmem_wmask_out  output  4  byte-lane enables (0000 on reads)
dmem_gnt_in  input  1  request accepted this cycle
dmem_rvalid_in  input  1  read data valid this cycle
dmem_rdata_in  input  32  read data
stall_out  output  1  freeze upstream pipeline
load_data_out  output  32  extended load result
load_valid_out  output  1  one-cycle pulse, load_data_out valid
rd_addr_out  output  5  captured rd, valid with load_valid_out
rf_wr_en_out  output  1  pulse with load_valid_out when captured rf_wr_en=1 and rd!=0
misaligned_out  output  1  one-cycle pulse, misaligned access rejected
bus_err_out  output  1  one-cycle pulse, bus timeout abort

Behaviour:
- Reset (rst_in=0 at edge): state IDLE. All registered outputs 0: dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out, load_data_out, load_valid_out, rd_addr_out, rf_wr_en_out, misaligned_out, bus_err_out. Timeout counter 0. Reset mid-access abandons the access; a later dmem_rvalid_in seen in IDLE is ignored.
- States: IDLE, REQ, WAIT.
- accept = IDLE & valid_in & (mem_rd_req_in | mem_wr_req_in) & aligned.
- Alignment rule: half requires addr[0]=0; word requires addr[1:0]=00; bytes are always aligned.
- Misaligned access in IDLE: no bus request and no state change; misaligned_out=1 next cycle for one cycle; no stall.
- On accept: capture addr, size, unsigned, rd, rf_wr_en, and the write flag. Drive the bus registers and go to REQ.
- REQ: dmem_req_out=1 with address, data and mask held stable. When dmem_gnt_in=1: a store goes to IDLE with dmem_req_out dropping next cycle; a load goes to WAIT.
- WAIT: dmem_req_out=0. When dmem_rvalid_in=1: go to IDLE and register load_data_out. load_valid_out=1 for one cycle in the following (IDLE) cycle.
- stall_out is combinational: accept | (state!=IDLE). Best-case load: accept at T, gnt at T+1, rvalid at T+2. stall_out is high T..T+2, load_valid_out is high at T+3. Best-case store: stall_out high T..T+1.
- Store lanes:
  - byte: wdata={4{rs2[7:0]}}, mask=0001<<addr[1:0]
  - half: wdata={2{rs2[15:0]}}, mask = addr[1] ? 1100 : 0011
  - word: wdata=rs2, mask=1111
- Load extract: select byte addr[1:0] or half addr[1], then sign/zero extend to 32 bits per load_unsigned. Word passes through unchanged.
- Only one access is outstanding at a time. valid_in while state!=IDLE is ignored, because upstream is stalled.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter increments every cycle in REQ or WAIT and clears on IDLE. If it reaches TIMEOUT_CYCLES without completion, the FSM returns to IDLE, dmem_req_out=0, and bus_err_out pulses for one cycle. No load_valid_out is produced, and stall releases next cycle.
- Undefined: no counter; the FSM waits indefinitely and bus_err_out is tied 0.

Test Plan:
- Reset: drive rst_in=0 for 2 cycles mid-load (state WAIT), then release -> every output is 0 and state is IDLE; a stray dmem_rvalid_in=1 produces no load_valid_out.
- Signed byte load: addr=0x1003, size=00, unsigned=0, rdata=0x80FF_FF7F, gnt and rvalid immediate -> load_data_out=0xFFFF_FF80 at T+3, rd_addr_out echoed, stall high T..T+2.
- Half store: addr=0x2002, rs2=0xDEAD_BEEF, gnt delayed 3 cycles -> dmem_addr_out=0x2000, wdata=0xBEEF_BEEF, mask=1100, all stable 3 cycles; stall releases the cycle after gnt.
- Misaligned word load at addr=0x3001 -> no dmem_req_out, misaligned_out pulses once, stall_out stays 0.
- Unsigned half load at addr=0x4002, rdata=0x8001_1234 -> load_data_out=0x0000_8001; rd=0 with rf_wr_en_in=1 -> rf_wr_en_out stays 0.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=8, gnt held 0 -> bus_err_out pulses after 8 REQ cycles, dmem_req_out drops, stall releases.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and memory.
// Request/grant for commands, rvalid for read data.
interface load_store_unit_if;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_wmask_out;
  logic        dmem_gnt_in;
  logic        dmem_rvalid_in;
  logic [31:0] dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_addr_out,
    output dmem_wdata_out, dmem_wmask_out,
    input  dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_addr_out,
    input  dmem_wdata_out, dmem_wmask_out,
    output dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding load/store on the dmem bus.
// Define LSU_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic        mem_rd_req_in,
  input  logic        mem_wr_req_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        rf_wr_en_in,
  load_store_unit_if.master dmem,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic [4:0]  rd_addr_out,
  output logic        rf_wr_en_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic        is_mem, aligned, accept, mis;
  logic        done, tmo, tmo_abort;
  logic        we_q, uns_q, rfwe_q;
  logic [1:0]  sz_q, off_q;
  logic [4:0]  rd_q;
  logic [31:0] wdata_nxt, sh, ext;
  logic [3:0]  mask_nxt;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign is_mem = valid_in & (mem_rd_req_in | mem_wr_req_in);

  always_comb begin
    aligned = 1'b1;
    if (load_size_in == 2'b01)
      aligned = ~iadder_in[0];
    else if (load_size_in[1])
      aligned = (iadder_in[1:0] == 2'b00);
  end

  assign accept    = (state == IDLE) & is_mem & aligned;
  assign mis       = (state == IDLE) & is_mem & ~aligned;
  assign stall_out = accept | (state != IDLE);

  assign done = ((state == REQ) & dmem.dmem_gnt_in & we_q)
              | ((state == WAIT) & dmem.dmem_rvalid_in);

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  assign tmo = (state != IDLE)
             & (tmo_cnt >= CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_in)
      tmo_cnt <= '0;
    else if (state == IDLE)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  // Parameter kept so both builds share one port list; never true.
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  assign tmo_abort = tmo & ~done;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ:  if (dmem.dmem_gnt_in)
              state_nxt = we_q ? IDLE : WAIT;
      WAIT: if (dmem.dmem_rvalid_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (tmo_abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    wdata_nxt = rs2_in;
    mask_nxt  = 4'b1111;
    unique case (1'b1)
      (load_size_in == 2'b00): begin
        wdata_nxt = {4{rs2_in[7:0]}};
        mask_nxt  = 4'b0001 << iadder_in[1:0];
      end
      (load_size_in == 2'b01): begin
        wdata_nxt = {2{rs2_in[15:0]}};
        mask_nxt  = iadder_in[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    sh     = dmem.dmem_rdata_in >> {off_q, 3'b000};
    byte_v = sh[7:0];
    half_v = off_q[1] ? dmem.dmem_rdata_in[31:16]
                      : dmem.dmem_rdata_in[15:0];
    ext    = dmem.dmem_rdata_in;
    unique case (1'b1)
      (sz_q == 2'b00):
        ext = {{24{~uns_q & byte_v[7]}}, byte_v};
      (sz_q == 2'b01):
        ext = {{16{~uns_q & half_v[15]}}, half_v};
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      dmem.dmem_req_out   <= 1'b0;
      dmem.dmem_we_out    <= 1'b0;
      dmem.dmem_addr_out  <= '0;
      dmem.dmem_wdata_out <= '0;
      dmem.dmem_wmask_out <= '0;
      load_data_out       <= '0;
      load_valid_out      <= 1'b0;
      rd_addr_out         <= '0;
      rf_wr_en_out        <= 1'b0;
      misaligned_out      <= 1'b0;
      bus_err_out         <= 1'b0;
      we_q                <= 1'b0;
      uns_q               <= 1'b0;
      rfwe_q              <= 1'b0;
      sz_q                <= '0;
      off_q               <= '0;
      rd_q                <= '0;
    end else begin
      load_valid_out <= 1'b0;
      rf_wr_en_out   <= 1'b0;
      misaligned_out <= mis;
      bus_err_out    <= tmo_abort;
      if (accept) begin
        dmem.dmem_req_out   <= 1'b1;
        dmem.dmem_we_out    <= mem_wr_req_in;
        dmem.dmem_addr_out  <= {iadder_in[31:2], 2'b00};
        dmem.dmem_wdata_out <= wdata_nxt;
        dmem.dmem_wmask_out <= mem_wr_req_in ? mask_nxt : 4'b0000;
        we_q   <= mem_wr_req_in;
        uns_q  <= load_unsigned_in;
        rfwe_q <= rf_wr_en_in;
        sz_q   <= load_size_in;
        off_q  <= iadder_in[1:0];
        rd_q   <= rd_addr_in;
      end
      if ((state == REQ) & dmem.dmem_gnt_in)
        dmem.dmem_req_out <= 1'b0;
      if ((state == WAIT) & dmem.dmem_rvalid_in) begin
        load_data_out  <= ext;
        load_valid_out <= 1'b1;
        rd_addr_out    <= rd_q;
        rf_wr_en_out   <= rfwe_q & (rd_q != 5'd0);
      end
      if (tmo_abort)
        dmem.dmem_req_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus random
// loads/stores against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in, mem_rd_req_in, mem_wr_req_in;
  logic [31:0] iadder_in, rs2_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [4:0]  rd_addr_in;
  logic        rf_wr_en_in;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic [4:0]  rd_addr_out;
  logic        rf_wr_en_out, misaligned_out, bus_err_out;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
    .mem_rd_req_in(mem_rd_req_in), .mem_wr_req_in(mem_wr_req_in),
    .iadder_in(iadder_in), .rs2_in(rs2_in),
    .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in),
    .rd_addr_in(rd_addr_in), .rf_wr_en_in(rf_wr_en_in),
    .dmem(bus.master), .stall_out(stall_out),
    .load_data_out(load_data_out),
    .load_valid_out(load_valid_out),
    .rd_addr_out(rd_addr_out), .rf_wr_en_out(rf_wr_en_out),
    .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rfwe;
  } ld_t;

  bus_t bus_q[$];
  ld_t  ld_q[$];
  int   stall_q[$];
  int   mis_exp = 0;
  int   berr_exp = 0;
  int   vectors = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  int   run = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit m_aligned(input logic [31:0] a,
                                   input logic [1:0] sz);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return a[0] == 1'b0;
    return a[1:0] == 2'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdat,
      input logic [31:0] a, input logic [1:0] sz, input bit uns);
    logic [31:0] v;
    int off;
    off = int'(a[1:0]);
    if (sz >= 2'd2) return rdat;
    if (sz == 2'd0) begin
      v = (rdat >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else begin
      v = (rdat >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d,
                                          input logic [1:0] sz);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] m_mask(input logic [31:0] a,
                                        input logic [1:0] sz);
    int off;
    off = int'(a[1:0]);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  // Monitor: compares whatever the DUT presents against queued expectations
  always @(negedge clk_in) begin
    if (!mon_on) begin
      run = 0;
    end else begin
      if (bus.dmem_req_out) begin
        if (bus_q.size() == 0) begin
          chk("req_unexpected", 32'(bus.dmem_req_out), 32'd0);
        end else begin
          chk("we", 32'(bus.dmem_we_out), 32'(bus_q[0].we));
          chk("addr", bus.dmem_addr_out, bus_q[0].addr);
          chk("mask", 32'(bus.dmem_wmask_out), 32'(bus_q[0].mask));
          if (bus_q[0].we)
            chk("wdata", bus.dmem_wdata_out, bus_q[0].wdata);
          if (bus.dmem_gnt_in) void'(bus_q.pop_front());
        end
      end
      if (load_valid_out) begin
        if (ld_q.size() == 0) begin
          chk("load_valid_unexpected", 32'(load_valid_out), 32'd0);
        end else begin
          chk("load_data", load_data_out, ld_q[0].data);
          chk("rd_addr", 32'(rd_addr_out), 32'(ld_q[0].rd));
          chk("rf_wr_en", 32'(rf_wr_en_out), 32'(ld_q[0].rfwe));
          void'(ld_q.pop_front());
        end
      end else if (rf_wr_en_out) begin
        chk("rf_wr_en_stray", 32'(rf_wr_en_out), 32'd0);
      end
      if (misaligned_out) begin
        chk("misaligned_pulse", 32'(mis_exp > 0), 32'd1);
        chk("misaligned_req", 32'(bus.dmem_req_out), 32'd0);
        if (mis_exp > 0) mis_exp--;
      end
      if (bus_err_out) begin
        chk("bus_err_pulse", 32'(berr_exp > 0), 32'd1);
        if (berr_exp > 0) berr_exp--;
      end
      if (stall_out) begin
        run++;
      end else if (run > 0) begin
        if (stall_q.size() == 0) begin
          chk("stall_unexpected", 32'(run), 32'd0);
        end else begin
          chk("stall_len", 32'(run), 32'(stall_q[0]));
          void'(stall_q.pop_front());
        end
        run = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_txn(input bit ld, input logic [31:0] a,
      input logic [31:0] d, input logic [1:0] sz, input bit uns,
      input logic [4:0] rd, input bit rfwe,
      input logic [31:0] rdat, input int gd, input int rvd);
    bus_t b;
    ld_t  l;
    bit   al;
    al = m_aligned(a, sz);
    if (al) begin
      b.we    = !ld;
      b.addr  = a & 32'hFFFF_FFFC;
      b.wdata = m_wdata(d, sz);
      b.mask  = ld ? 4'h0 : m_mask(a, sz);
      bus_q.push_back(b);
      if (ld) begin
        l.data = m_load(rdat, a, sz, uns);
        l.rd   = rd;
        l.rfwe = rfwe && (rd != 5'd0);
        ld_q.push_back(l);
      end
      stall_q.push_back(ld ? 3 + gd + rvd : 2 + gd);
    end else begin
      mis_exp++;
    end
    valid_in = 1'b1;
    mem_rd_req_in = ld;
    mem_wr_req_in = !ld;
    iadder_in = a;
    rs2_in = d;
    load_size_in = sz;
    load_unsigned_in = uns;
    rd_addr_in = rd;
    rf_wr_en_in = rfwe;
    tick();
    valid_in = 1'b0;
    mem_rd_req_in = 1'b0;
    mem_wr_req_in = 1'b0;
    iadder_in = $urandom;
    rs2_in = $urandom;
    if (al) begin
      repeat (gd) tick();
      bus.dmem_gnt_in = 1'b1;
      tick();
      bus.dmem_gnt_in = 1'b0;
      if (ld) begin
        repeat (rvd) tick();
        bus.dmem_rvalid_in = 1'b1;
        bus.dmem_rdata_in = rdat;
        tick();
        bus.dmem_rvalid_in = 1'b0;
        bus.dmem_rdata_in = $urandom;
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0;
    valid_in = 1'b0;
    mem_rd_req_in = 1'b0;
    mem_wr_req_in = 1'b0;
    iadder_in = '0;
    rs2_in = '0;
    load_size_in = '0;
    load_unsigned_in = 1'b0;
    rd_addr_in = '0;
    rf_wr_en_in = 1'b0;
    bus.dmem_gnt_in = 1'b0;
    bus.dmem_rvalid_in = 1'b0;
    bus.dmem_rdata_in = '0;
    repeat (2) tick();
    rst_in = 1'b1;
    chk("rst_req", 32'(bus.dmem_req_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_load_valid", 32'(load_valid_out), 32'd0);

    // Reset in the middle of a load that is waiting for data
    valid_in = 1'b1;
    mem_rd_req_in = 1'b1;
    iadder_in = 32'h0000_0100;
    load_size_in = 2'd2;
    rd_addr_in = 5'd7;
    rf_wr_en_in = 1'b1;
    tick();
    valid_in = 1'b0;
    mem_rd_req_in = 1'b0;
    bus.dmem_gnt_in = 1'b1;
    tick();
    bus.dmem_gnt_in = 1'b0;
    chk("wait_stall", 32'(stall_out), 32'd1);
    rst_in = 1'b0;
    repeat (2) tick();
    rst_in = 1'b1;
    chk("mid_rst_req", 32'(bus.dmem_req_out), 32'd0);
    chk("mid_rst_we", 32'(bus.dmem_we_out), 32'd0);
    chk("mid_rst_addr", bus.dmem_addr_out, 32'd0);
    chk("mid_rst_wdata", bus.dmem_wdata_out, 32'd0);
    chk("mid_rst_mask", 32'(bus.dmem_wmask_out), 32'd0);
    chk("mid_rst_ldata", load_data_out, 32'd0);
    chk("mid_rst_lvalid", 32'(load_valid_out), 32'd0);
    chk("mid_rst_rd", 32'(rd_addr_out), 32'd0);
    chk("mid_rst_rfwe", 32'(rf_wr_en_out), 32'd0);
    chk("mid_rst_mis", 32'(misaligned_out), 32'd0);
    chk("mid_rst_berr", 32'(bus_err_out), 32'd0);
    chk("mid_rst_stall", 32'(stall_out), 32'd0);
    bus.dmem_rvalid_in = 1'b1;
    bus.dmem_rdata_in = 32'h1234_5678;
    tick();
    bus.dmem_rvalid_in = 1'b0;
    chk("stray_rvalid_0", 32'(load_valid_out), 32'd0);
    tick();
    chk("stray_rvalid_1", 32'(load_valid_out), 32'd0);
    chk("stray_stall", 32'(stall_out), 32'd0);
    mon_on = 1'b1;

    do_txn(1, 32'h1003, 32'h0, 2'd0, 0, 5'd5, 1,
           32'h80FF_FF7F, 0, 0);
    do_txn(0, 32'h2002, 32'hDEAD_BEEF, 2'd1, 0, 5'd0, 0,
           32'h0, 3, 0);
    do_txn(1, 32'h3001, 32'h0, 2'd2, 0, 5'd3, 1,
           32'h0, 0, 0);
    do_txn(1, 32'h4002, 32'h0, 2'd1, 1, 5'd0, 1,
           32'h8001_1234, 1, 2);

`ifdef LSU_TIMEOUT_EN
    begin
      bus_t b;
      b.we = 1'b0;
      b.addr = 32'h5000;
      b.wdata = '0;
      b.mask = 4'h0;
      bus_q.push_back(b);
      stall_q.push_back(9);
      berr_exp++;
      valid_in = 1'b1;
      mem_rd_req_in = 1'b1;
      iadder_in = 32'h5000;
      load_size_in = 2'd2;
      tick();
      valid_in = 1'b0;
      mem_rd_req_in = 1'b0;
      repeat (12) tick();
      chk("tmo_req_drop", 32'(bus.dmem_req_out), 32'd0);
      chk("tmo_stall", 32'(stall_out), 32'd0);
      if (bus_q.size() > 0) void'(bus_q.pop_front());
    end
`endif

    for (int i = 0; i < 300; i++) begin
      do_txn($urandom_range(0, 1) == 1, $urandom, $urandom,
             2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (5) tick();
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("ld_q_empty", 32'(ld_q.size()), 32'd0);
    chk("stall_q_empty", 32'(stall_q.size()), 32'd0);
    chk("mis_outstanding", 32'(mis_exp), 32'd0);
    chk("berr_outstanding", 32'(berr_exp), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
